icache_resp: RTL

- Instruction-side responder for the fetch stage: takes fetch's PC and returns the instruction word.
- Direct-mapped, read-only instruction cache.
- On a hit the instruction is returned combinationally in the same cycle, so it lines up with fetch's registered PC.
- On a miss it raises a stall, fetches the whole line from memory over a req/ack handshake, fills the line, then serves the hit.

---
 rtl/core_pkg.sv | 15 +
 rtl/icache_array.sv | 49 ++++
 rtl/icache_resp.sv | 110 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding, refill FSM states, and the
// reset/exception vectors that fetch and the icache both rely on.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_1000;
  localparam logic [31:0] EXC_PC    = 32'h0000_2000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped icache.
// Ports: async read (rd_idx_i/rd_off_i -> valid, tag, word),
// one line-wide write port (we_i, wr_idx_i, wr_tag_i, wr_line_i).
// Only the valid bits are reset (sync, active-low rsn_i).
module icache_array #(
  parameter int LINES = 4,
  parameter int WORDS = 4,
  parameter int IDX_W = 2,
  parameter int OFF_W = 2,
  parameter int TAG_W = 26
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  input  logic [OFF_W-1:0]       rd_off_i,
  output logic                   rd_valid_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic [31:0]            rd_data_o,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [TAG_W-1:0]       wr_tag_i,
  input  logic [32*WORDS-1:0]    wr_line_i
);

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [32*WORDS-1:0] data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data are left unreset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (rsn_i && we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][32*rd_off_i +: 32];

endmodule

// File: rtl/icache_resp.sv
// Fetch-side direct-mapped read-only icache with zero-latency hits.
// Ports: pc_i in, instr_o/hit_o/stall_o out; line refill over
// mem_req_o/mem_addr_o -> mem_ack_i/mem_data_i. Sync active-low rsn_i.
module icache_resp
  import core_pkg::*;
#(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic [31:0]         pc_i,
  output logic [31:0]         instr_o,
  output logic                hit_o,
  output logic                stall_o,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [32*WORDS-1:0] mem_data_i
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - 2 - OB - IB;

  icache_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we;

  logic [OB-1:0] off;
  logic [IB-1:0] idx;
  logic [TW-1:0] tag;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data;
  logic          hit;
  logic          unused_pc_lsb;

  assign off = pc_i[2 +: OB];
  assign idx = pc_i[2+OB +: IB];
  assign tag = pc_i[31 -: TW];
  assign unused_pc_lsb = ^pc_i[1:0];

  icache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDX_W (IB),
    .OFF_W (OB),
    .TAG_W (TW)
  ) u_array (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .rd_idx_i   (idx),
    .rd_off_i   (off),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (we),
    .wr_idx_i   (addr_q[2+OB +: IB]),
    .wr_tag_i   (addr_q[31 -: TW]),
    .wr_line_i  (mem_data_i)
  );

  // Hits are only honoured in IDLE so a line being filled is never
  // served in the same cycle it is written.
  assign hit = rd_valid && (rd_tag == tag) && (state_q == IDLE);

  assign hit_o      = hit;
  assign stall_o    = !hit;
  assign instr_o    = hit ? rd_data : NOP_INSTR;
  assign mem_req_o  = (state_q == REQ);
  assign mem_addr_o = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          addr_d  = {pc_i[31:2+OB], {(2+OB){1'b0}}};
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          we      = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

endmodule
